// File: rtl/dmac_engine_pkg.sv
// Shared types and constants for the DMAC transfer engine.
// The optional sticky interrupt is enabled by defining DMAC_ENGINE_INTR_EN.
package dmac_engine_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ADDR_INC_DEFAULT = 32'h1;
  localparam logic [DATA_W-1:0] DESC_SIZE_ZERO   = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_REQ,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dmac_engine_if.sv
// Descriptor FIFO and shared memory bus signals between the engine and its surroundings.
interface dmac_engine_if;

  logic                                fifo_empty;
  logic                                fifo_rd_en;
  logic [dmac_engine_pkg::DATA_W-1:0]  fifo_dout0;
  logic [dmac_engine_pkg::DATA_W-1:0]  fifo_dout1;
  logic [dmac_engine_pkg::DATA_W-1:0]  fifo_dout2;
  logic                                m_req;
  logic                                m_grant;
  logic                                m_we;
  logic                                m_en;
  logic [dmac_engine_pkg::DATA_W-1:0]  m_addr;
  logic [dmac_engine_pkg::DATA_W-1:0]  m_dout;
  logic [dmac_engine_pkg::DATA_W-1:0]  m_din;

  modport master (
    input  fifo_empty, fifo_dout0, fifo_dout1, fifo_dout2, m_grant, m_din,
    output fifo_rd_en, m_req, m_we, m_en, m_addr, m_dout
  );

  modport slave (
    output fifo_empty, fifo_dout0, fifo_dout1, fifo_dout2, m_grant, m_din,
    input  fifo_rd_en, m_req, m_we, m_en, m_addr, m_dout
  );

endinterface

// File: rtl/dmac_engine_dp.sv
// Engine datapath: source/destination/count/read-buffer registers and the bus address/data mux.
module dmac_engine_dp
  import dmac_engine_pkg::*;
#(
  parameter logic [DATA_W-1:0] ADDR_INC = ADDR_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch_i,
  input  logic              capture_i,
  input  logic              step_i,
  input  logic              rd_sel_i,
  input  logic              wr_sel_i,
  input  logic [DATA_W-1:0] src_i,
  input  logic [DATA_W-1:0] dst_i,
  input  logic [DATA_W-1:0] size_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              last_o
);

  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    rbuf_d = rbuf_q;
    if (latch_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = size_i;
    end
    if (step_i) begin
      src_d = src_q + ADDR_INC;
      dst_d = dst_q + ADDR_INC;
      cnt_d = cnt_q - 32'd1;
    end
    if (capture_i) begin
      rbuf_d = rdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      rbuf_q <= '0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
      rbuf_q <= rbuf_d;
    end
  end

  // Idle bus cycles drive zeros so several masters can be OR-combined.
  assign addr_o  = rd_sel_i ? src_q : (wr_sel_i ? dst_q : '0);
  assign wdata_o = wr_sel_i ? rbuf_q : '0;
  assign last_o  = (cnt_q == 32'd1);

endmodule

// File: rtl/dmac_engine.sv
// DMAC transfer engine: pops descriptors and copies words one read/write pair at a time.
// Define DMAC_ENGINE_INTR_EN to get a sticky interrupt flag cleared by intr_clr.
module dmac_engine
  import dmac_engine_pkg::*;
#(
  parameter logic [DATA_W-1:0] ADDR_INC = ADDR_INC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_start,
  input  logic          intr_clr,
  dmac_engine_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          interrupt
);

  state_e state_q, state_d;

  logic fifoRdEn, mReq, mEn, mWe;
  logic latchDesc, captureRd, stepAddr, rdSel, wrSel, lastWord;
  logic [DATA_W-1:0] mAddr, mDout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Grant is only looked at in REQ and at the end of WR, so a read/write pair is never split.
  always_comb begin
    state_d   = state_q;
    fifoRdEn  = 1'b0;
    mReq      = 1'b0;
    mEn       = 1'b0;
    mWe       = 1'b0;
    latchDesc = 1'b0;
    captureRd = 1'b0;
    stepAddr  = 1'b0;
    rdSel     = 1'b0;
    wrSel     = 1'b0;
    case (state_q)
      ST_IDLE:  if (op_start && !bus.fifo_empty) state_d = ST_POP;
      ST_POP: begin
        fifoRdEn = 1'b1;
        state_d  = ST_LATCH;
      end
      ST_LATCH: begin
        latchDesc = 1'b1;
        state_d   = (bus.fifo_dout2 == DESC_SIZE_ZERO) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        mReq = 1'b1;
        if (bus.m_grant) state_d = ST_RD;
      end
      ST_RD: begin
        mReq    = 1'b1;
        mEn     = 1'b1;
        rdSel   = 1'b1;
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        mReq      = 1'b1;
        captureRd = 1'b1;
        state_d   = ST_WR;
      end
      ST_WR: begin
        mReq     = 1'b1;
        mEn      = 1'b1;
        mWe      = 1'b1;
        wrSel    = 1'b1;
        stepAddr = 1'b1;
        if (lastWord)         state_d = ST_DONE;
        else if (bus.m_grant) state_d = ST_RD;
        else                  state_d = ST_REQ;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  dmac_engine_dp #(.ADDR_INC(ADDR_INC)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .latch_i   (latchDesc),
    .capture_i (captureRd),
    .step_i    (stepAddr),
    .rd_sel_i  (rdSel),
    .wr_sel_i  (wrSel),
    .src_i     (bus.fifo_dout0),
    .dst_i     (bus.fifo_dout1),
    .size_i    (bus.fifo_dout2),
    .rdata_i   (bus.m_din),
    .addr_o    (mAddr),
    .wdata_o   (mDout),
    .last_o    (lastWord)
  );

  assign bus.fifo_rd_en = fifoRdEn;
  assign bus.m_req      = mReq;
  assign bus.m_en       = mEn;
  assign bus.m_we       = mWe;
  assign bus.m_addr     = mAddr;
  assign bus.m_dout     = mDout;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

`ifdef DMAC_ENGINE_INTR_EN
  logic intr_q;

  // Setting in DONE takes priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   intr_q <= 1'b0;
    else if (state_q == ST_DONE) intr_q <= 1'b1;
    else if (intr_clr)           intr_q <= 1'b0;
  end

  assign interrupt = intr_q;
`else
  logic intr_clr_unused;
  assign intr_clr_unused = intr_clr;
  assign interrupt       = 1'b0;
`endif

endmodule
